// File: rtl/rom_stream_reader.sv
// Burst reader: streams a run of consecutive ROM words out through a valid/ready port.
// Reads are issued only while buffer space exists, so back-pressure never loses data.
module rom_stream_reader #(
    parameter int c_ADDR_WIDTH = 10,
    parameter int c_DATA_WIDTH = 32,
    parameter int c_OUTPUT_REG = 0,
    parameter int c_FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [c_ADDR_WIDTH-1:0] start_addr,
    input  logic [c_ADDR_WIDTH:0]   length,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [c_ADDR_WIDTH-1:0] rom_addr,
    input  logic [c_DATA_WIDTH-1:0] rom_rd_data,
    output logic                    rom_clk_en,
    output logic                    rom_addr_strobe,
    output logic                    rom_rd_oce,
    output logic [c_DATA_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last
);

    localparam int unsigned L  = 1 + c_OUTPUT_REG;
    localparam int unsigned PW = $clog2(c_FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(c_FIFO_DEPTH);
    localparam logic [c_ADDR_WIDTH:0] CNT_ONE = {{c_ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [c_ADDR_WIDTH-1:0] issue_addr;
    logic [c_ADDR_WIDTH:0]   issue_rem;
    logic [c_ADDR_WIDTH:0]   out_rem;
    logic [L-1:0]            inflight;
    logic [c_DATA_WIDTH-1:0] mem [c_FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic [CW:0]             occupancy;
    logic                    load, issue, push, pop, clear, done_nxt;

    assign rom_clk_en      = 1'b1;
    assign rom_addr_strobe = 1'b0;
    assign rom_rd_oce      = 1'b1;
    assign rom_addr        = issue_addr;
    assign busy            = (state != IDLE);
    assign m_valid         = (count != '0);
    assign m_data          = m_valid ? mem[rd_ptr] : '0;
    assign m_last          = m_valid && (out_rem == CNT_ONE);
    assign push            = inflight[L-1];
    assign pop             = m_valid && m_ready;

    // Words in flight already own a buffer slot, so they count toward occupancy.
    always_comb begin
        occupancy = {1'b0, count}
                  + {{CW{1'b0}}, inflight[0]}
                  + {{CW{1'b0}}, (L > 1) ? inflight[L-1] : 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        issue     = 1'b0;
        clear     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (length == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                if (abort) begin
                    clear     = 1'b1;
                    state_nxt = IDLE;
                end else if (issue_rem != '0 && occupancy < DEPTH_V) begin
                    issue = 1'b1;
                    if (issue_rem == CNT_ONE) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    clear     = 1'b1;
                    state_nxt = IDLE;
                end else if (pop && out_rem == CNT_ONE) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_addr <= '0;
            issue_rem  <= '0;
            out_rem    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            done       <= 1'b0;
        end else begin
            done <= done_nxt;
            if (clear) begin
                issue_addr <= '0;
                issue_rem  <= '0;
                out_rem    <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
            end else begin
                if (load) begin
                    issue_addr <= start_addr;
                    issue_rem  <= length;
                    out_rem    <= length;
                end else if (issue) begin
                    issue_addr <= issue_addr + 1'b1;
                    issue_rem  <= issue_rem - CNT_ONE;
                end
                if (pop) begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    out_rem <= out_rem - CNT_ONE;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= rom_rd_data;
    end

    // A read issued at cycle t returns rom_rd_data at t+L; this shift register marks those cycles.
    if (L == 1) begin : g_lat1
        always_ff @(posedge clk or posedge rst) begin
            if (rst)        inflight <= '0;
            else if (clear) inflight <= '0;
            else            inflight <= issue;
        end
    end else begin : g_latn
        always_ff @(posedge clk or posedge rst) begin
            if (rst)        inflight <= '0;
            else if (clear) inflight <= '0;
            else            inflight <= {inflight[L-2:0], issue};
        end
    end

endmodule
